// File: rtl/io_port_bridge.sv
// io_port_bridge: host-side endpoint of the core's 16-bit IN/OUT ports.
//   Output path: every core OUT write (cpu_out_we_i) is pushed into an output FIFO
//   that the host drains with a valid/ready handshake (host_rx_*).
//   Input path: host words (host_tx_*) are buffered in an input FIFO whose head
//   is presented to the core on cpu_in_o and popped by cpu_in_rd_i.
//   Sticky error flags: out_ovf_o (OUT write dropped on a full FIFO) and
//   in_udf_o (IN read of an empty FIFO); cleared by clr_err_i.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   cpu_out_i/_we_i       core OUT word and strobe
//   cpu_in_o/_rd_i        input FIFO head and core consume strobe
//   cpu_in_avail_o        input FIFO non-empty
//   host_rx_data/valid_o, host_rx_ready_i   output FIFO drain side
//   host_tx_data/valid_i, host_tx_ready_o   input FIFO fill side
//   out_level_o, in_level_o                 FIFO occupancies
//   out_ovf_o, in_udf_o, clr_err_i          sticky error flags and clear
module io_port_bridge #(
  parameter int unsigned DataW    = 16,
  parameter int unsigned OutDepth = 4,
  parameter int unsigned InDepth  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DataW-1:0]            cpu_out_i,
  input  logic                        cpu_out_we_i,
  output logic [DataW-1:0]            cpu_in_o,
  input  logic                        cpu_in_rd_i,
  output logic                        cpu_in_avail_o,
  output logic [DataW-1:0]            host_rx_data_o,
  output logic                        host_rx_valid_o,
  input  logic                        host_rx_ready_i,
  input  logic [DataW-1:0]            host_tx_data_i,
  input  logic                        host_tx_valid_i,
  output logic                        host_tx_ready_o,
  output logic [$clog2(OutDepth):0]   out_level_o,
  output logic [$clog2(InDepth):0]    in_level_o,
  output logic                        out_ovf_o,
  output logic                        in_udf_o,
  input  logic                        clr_err_i
);

  localparam int unsigned OutAw = $clog2(OutDepth);
  localparam int unsigned InAw  = $clog2(InDepth);
  localparam int unsigned OutLw = OutAw + 1;
  localparam int unsigned InLw  = InAw + 1;
  localparam logic [OutLw-1:0] OutFullLvl = OutLw'(OutDepth);
  localparam logic [InLw-1:0]  InFullLvl  = InLw'(InDepth);

  logic [DataW-1:0] out_mem_q [OutDepth];
  logic [OutAw-1:0] out_wptr_q, out_rptr_q;
  logic [OutLw-1:0] out_level_q, out_level_d;

  logic [DataW-1:0] in_mem_q [InDepth];
  logic [InAw-1:0]  in_wptr_q, in_rptr_q;
  logic [InLw-1:0]  in_level_q, in_level_d;

  logic out_ovf_q, out_ovf_d;
  logic in_udf_q, in_udf_d;

  logic out_full, out_push, out_pop, out_ovf_set;
  logic in_nempty, in_push, in_pop, in_udf_set;

  // Handshake outputs are forced low while reset is asserted, so the host never
  // sees a partial transfer during a reset that lands mid-stream.
  always_comb begin
    out_full        = (out_level_q == OutFullLvl);
    in_nempty       = (in_level_q != '0);

    host_rx_valid_o = rst_ni && (out_level_q != '0);
    host_rx_data_o  = out_mem_q[out_rptr_q];
    host_tx_ready_o = rst_ni && (in_level_q != InFullLvl);
    cpu_in_avail_o  = rst_ni && in_nempty;
    cpu_in_o        = cpu_in_avail_o ? in_mem_q[in_rptr_q] : '0;

    out_pop     = host_rx_valid_o && host_rx_ready_i;
    // A full FIFO still accepts a write when the host drains in the same cycle.
    out_push    = cpu_out_we_i && (!out_full || out_pop);
    out_ovf_set = cpu_out_we_i && out_full && !out_pop;

    in_push     = host_tx_valid_i && host_tx_ready_o;
    in_pop      = cpu_in_rd_i && in_nempty;
    // Empty-FIFO reads flag underflow even if a host word arrives that cycle;
    // the new word is stored, not bypassed to the core.
    in_udf_set  = cpu_in_rd_i && !in_nempty;

    out_level_d = out_level_q + OutLw'(out_push) - OutLw'(out_pop);
    in_level_d  = in_level_q + InLw'(in_push) - InLw'(in_pop);

    // Setting wins over clearing in the same cycle.
    out_ovf_d = out_ovf_set ? 1'b1 : (clr_err_i ? 1'b0 : out_ovf_q);
    in_udf_d  = in_udf_set  ? 1'b1 : (clr_err_i ? 1'b0 : in_udf_q);

    out_level_o = out_level_q;
    in_level_o  = in_level_q;
    out_ovf_o   = out_ovf_q;
    in_udf_o    = in_udf_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_wptr_q  <= '0;
      out_rptr_q  <= '0;
      out_level_q <= '0;
      in_wptr_q   <= '0;
      in_rptr_q   <= '0;
      in_level_q  <= '0;
      out_ovf_q   <= 1'b0;
      in_udf_q    <= 1'b0;
      for (int i = 0; i < int'(OutDepth); i++) out_mem_q[i] <= '0;
      for (int i = 0; i < int'(InDepth); i++)  in_mem_q[i]  <= '0;
    end else begin
      if (out_push) begin
        out_mem_q[out_wptr_q] <= cpu_out_i;
        out_wptr_q            <= out_wptr_q + 1'b1;
      end
      if (out_pop) out_rptr_q <= out_rptr_q + 1'b1;
      if (in_push) begin
        in_mem_q[in_wptr_q] <= host_tx_data_i;
        in_wptr_q           <= in_wptr_q + 1'b1;
      end
      if (in_pop) in_rptr_q <= in_rptr_q + 1'b1;
      out_level_q <= out_level_d;
      in_level_q  <= in_level_d;
      out_ovf_q   <= out_ovf_d;
      in_udf_q    <= in_udf_d;
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed testbench for io_port_bridge (DataW=16, depths 4).
module tb_io_port_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] cpu_out_i = '0;
  logic        cpu_out_we_i = 1'b0;
  logic [15:0] cpu_in_o;
  logic        cpu_in_rd_i = 1'b0;
  logic        cpu_in_avail_o;
  logic [15:0] host_rx_data_o;
  logic        host_rx_valid_o;
  logic        host_rx_ready_i = 1'b0;
  logic [15:0] host_tx_data_i = '0;
  logic        host_tx_valid_i = 1'b0;
  logic        host_tx_ready_o;
  logic [2:0]  out_level_o;
  logic [2:0]  in_level_o;
  logic        out_ovf_o;
  logic        in_udf_o;
  logic        clr_err_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  io_port_bridge #(
    .DataW   (16),
    .OutDepth(4),
    .InDepth (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cpu_out_i      (cpu_out_i),
    .cpu_out_we_i   (cpu_out_we_i),
    .cpu_in_o       (cpu_in_o),
    .cpu_in_rd_i    (cpu_in_rd_i),
    .cpu_in_avail_o (cpu_in_avail_o),
    .host_rx_data_o (host_rx_data_o),
    .host_rx_valid_o(host_rx_valid_o),
    .host_rx_ready_i(host_rx_ready_i),
    .host_tx_data_i (host_tx_data_i),
    .host_tx_valid_i(host_tx_valid_i),
    .host_tx_ready_o(host_tx_ready_o),
    .out_level_o    (out_level_o),
    .in_level_o     (in_level_o),
    .out_ovf_o      (out_ovf_o),
    .in_udf_o       (in_udf_o),
    .clr_err_i      (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    host_tx_valid_i = 1'b1;
    host_tx_data_i  = 16'h1234;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({host_tx_ready_o, host_rx_valid_o, cpu_in_avail_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_handshake: got %b expected 000",
                 {host_tx_ready_o, host_rx_valid_o, cpu_in_avail_o});
      end
      n_checks++;
      if (cpu_in_o !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_cpu_in: got %h expected 0000", cpu_in_o);
      end
      n_checks++;
      if ({out_level_o, in_level_o, out_ovf_o, in_udf_o} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state: got lvl %0d/%0d ovf %b udf %b expected zeros",
                 out_level_o, in_level_o, out_ovf_o, in_udf_o);
      end
    end
    rst_ni = 1'b1;
    host_tx_valid_i = 1'b0;
    #1;
    n_checks++;
    if (host_tx_ready_o !== 1'b1 || out_level_o !== 3'd0 || in_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: got ready %b lvl %0d/%0d expected 1 0/0",
               host_tx_ready_o, out_level_o, in_level_o);
    end
  endtask

  task automatic test_out_overflow();
    logic [15:0] exp;
    for (int i = 1; i <= 5; i++) begin
      cpu_out_i    = 16'h1111 * 16'(i);
      cpu_out_we_i = 1'b1;
      tick();
      if (i == 1) begin
        n_checks++;
        if (host_rx_valid_o !== 1'b1 || host_rx_data_o !== 16'h1111) begin
          n_fail++;
          $display("FAIL out_first_visible: got v%b %h expected v1 1111",
                   host_rx_valid_o, host_rx_data_o);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (out_level_o !== 3'd4 || out_ovf_o !== 1'b0) begin
          n_fail++;
          $display("FAIL out_fill: got lvl %0d ovf %b expected 4 0", out_level_o, out_ovf_o);
        end
      end
    end
    cpu_out_we_i = 1'b0;
    n_checks++;
    if (out_level_o !== 3'd4 || out_ovf_o !== 1'b1) begin
      n_fail++;
      $display("FAIL out_ovf: got lvl %0d ovf %b expected 4 1", out_level_o, out_ovf_o);
    end
    host_rx_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      exp = 16'h1111 * 16'(i);
      n_checks++;
      if (host_rx_valid_o !== 1'b1 || host_rx_data_o !== exp) begin
        n_fail++;
        $display("FAIL out_drain_%0d: got v%b %h expected v1 %h",
                 i, host_rx_valid_o, host_rx_data_o, exp);
      end
      tick();
    end
    host_rx_ready_i = 1'b0;
    n_checks++;
    if (host_rx_valid_o !== 1'b0 || out_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL out_drained: got v%b lvl %0d expected v0 0", host_rx_valid_o, out_level_o);
    end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    n_checks++;
    if (out_ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL out_ovf_clear: got %b expected 0", out_ovf_o);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_q [5];
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA};
    for (int i = 0; i < 4; i++) begin
      cpu_out_i    = exp_q[i];
      cpu_out_we_i = 1'b1;
      tick();
    end
    cpu_out_i       = 16'hAAAA;
    host_rx_ready_i = 1'b1;
    #1;
    n_checks++;
    if (host_rx_data_o !== 16'h1111) begin
      n_fail++;
      $display("FAIL full_pp_head: got %h expected 1111", host_rx_data_o);
    end
    tick();
    cpu_out_we_i    = 1'b0;
    host_rx_ready_i = 1'b0;
    n_checks++;
    if (out_level_o !== 3'd4 || out_ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pp_level: got lvl %0d ovf %b expected 4 0", out_level_o, out_ovf_o);
    end
    host_rx_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      n_checks++;
      if (host_rx_valid_o !== 1'b1 || host_rx_data_o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_pp_drain_%0d: got v%b %h expected v1 %h",
                 i, host_rx_valid_o, host_rx_data_o, exp_q[i]);
      end
      tick();
    end
    host_rx_ready_i = 1'b0;
    n_checks++;
    if (out_level_o !== 3'd0 || out_ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pp_end: got lvl %0d ovf %b expected 0 0", out_level_o, out_ovf_o);
    end
  endtask

  task automatic test_in_fifo();
    for (int i = 1; i <= 4; i++) begin
      host_tx_data_i  = 16'(i);
      host_tx_valid_i = 1'b1;
      #1;
      n_checks++;
      if (host_tx_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL in_ready_%0d: got %b expected 1", i, host_tx_ready_o);
      end
      tick();
    end
    host_tx_valid_i = 1'b0;
    n_checks++;
    if (host_tx_ready_o !== 1'b0 || in_level_o !== 3'd4 || cpu_in_o !== 16'h0001) begin
      n_fail++;
      $display("FAIL in_full: got ready %b lvl %0d head %h expected 0 4 0001",
               host_tx_ready_o, in_level_o, cpu_in_o);
    end
    for (int i = 1; i <= 4; i++) begin
      cpu_in_rd_i = 1'b1;
      #1;
      n_checks++;
      if (cpu_in_o !== 16'(i) || cpu_in_avail_o !== 1'b1) begin
        n_fail++;
        $display("FAIL in_read_%0d: got avail %b %h expected 1 %h",
                 i, cpu_in_avail_o, cpu_in_o, 16'(i));
      end
      tick();
    end
    cpu_in_rd_i = 1'b0;
    n_checks++;
    if (cpu_in_avail_o !== 1'b0 || in_level_o !== 3'd0 || cpu_in_o !== 16'h0 ||
        in_udf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL in_empty: got avail %b lvl %0d data %h udf %b expected 0 0 0000 0",
               cpu_in_avail_o, in_level_o, cpu_in_o, in_udf_o);
    end
  endtask

  task automatic test_udf_no_bypass();
    cpu_in_rd_i     = 1'b1;
    host_tx_valid_i = 1'b1;
    host_tx_data_i  = 16'hBEEF;
    #1;
    n_checks++;
    if (cpu_in_o !== 16'h0) begin
      n_fail++;
      $display("FAIL udf_bypass: got %h expected 0000", cpu_in_o);
    end
    tick();
    cpu_in_rd_i     = 1'b0;
    host_tx_valid_i = 1'b0;
    n_checks++;
    if (in_udf_o !== 1'b1 || cpu_in_o !== 16'hBEEF || in_level_o !== 3'd1) begin
      n_fail++;
      $display("FAIL udf_set: got udf %b data %h lvl %0d expected 1 beef 1",
               in_udf_o, cpu_in_o, in_level_o);
    end
    // Set beats clear: read empty? No -- FIFO holds BEEF, so this read is legal.
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    n_checks++;
    if (in_udf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_clear: got %b expected 0", in_udf_o);
    end
    cpu_in_rd_i = 1'b1;
    tick();
    // Second read on an empty FIFO with clr_err high: flag must still set.
    clr_err_i = 1'b1;
    tick();
    cpu_in_rd_i = 1'b0;
    clr_err_i   = 1'b0;
    n_checks++;
    if (in_udf_o !== 1'b1 || in_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL udf_set_priority: got udf %b lvl %0d expected 1 0", in_udf_o, in_level_o);
    end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int o_sent = 0, o_got = 0, i_sent = 0, i_got = 0;
    int cyc = 0;
    while ((o_got < 20 || i_got < 20) && cyc < 600) begin
      cpu_out_we_i    = (o_sent < 20) && (out_level_o != 3'd4) && ($urandom_range(0, 1) == 1);
      cpu_out_i       = 16'h1000 + 16'(o_sent);
      host_rx_ready_i = ($urandom_range(0, 1) == 1);
      host_tx_valid_i = (i_sent < 20) && ($urandom_range(0, 1) == 1);
      host_tx_data_i  = 16'h2000 + 16'(i_sent);
      cpu_in_rd_i     = cpu_in_avail_o && ($urandom_range(0, 1) == 1);
      #1;
      if (host_rx_valid_o && host_rx_ready_i) begin
        n_checks++;
        if (host_rx_data_o !== 16'h1000 + 16'(o_got)) begin
          n_fail++;
          $display("FAIL b2b_out_%0d: got %h expected %h", o_got, host_rx_data_o,
                   16'h1000 + 16'(o_got));
        end
        o_got++;
      end
      if (cpu_in_rd_i) begin
        n_checks++;
        if (cpu_in_o !== 16'h2000 + 16'(i_got)) begin
          n_fail++;
          $display("FAIL b2b_in_%0d: got %h expected %h", i_got, cpu_in_o,
                   16'h2000 + 16'(i_got));
        end
        i_got++;
      end
      if (cpu_out_we_i) o_sent++;
      if (host_tx_valid_i && host_tx_ready_o) i_sent++;
      tick();
      cyc++;
    end
    cpu_out_we_i    = 1'b0;
    host_rx_ready_i = 1'b0;
    host_tx_valid_i = 1'b0;
    cpu_in_rd_i     = 1'b0;
    n_checks++;
    if (o_got != 20 || i_got != 20) begin
      n_fail++;
      $display("FAIL b2b_count: got out %0d in %0d expected 20 20", o_got, i_got);
    end
    n_checks++;
    if (out_ovf_o !== 1'b0 || in_udf_o !== 1'b0 || out_level_o !== 3'd0 ||
        in_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_flags: got ovf %b udf %b lvl %0d/%0d expected 0 0 0/0",
               out_ovf_o, in_udf_o, out_level_o, in_level_o);
    end
  endtask

  initial begin
    test_reset();
    test_out_overflow();
    test_full_push_pop();
    test_in_fifo();
    test_udf_no_bypass();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
